// File: rtl/add_seq_pkg.sv
// Shared types and constants for the byte-serial add sequencer.
// Build option: ADD_SEQ_SUB_EN enables the subtract path (see add_seq_ctrl).
package add_seq_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_NBYTES = 4;
  localparam int MAX_NBYTES     = 8;
  localparam int IDX_W          = $clog2(MAX_NBYTES);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Requester-side handshake and result bus of the add sequencer.
// Build option: ADD_SEQ_SUB_EN adds the sub request line.
interface add_seq_ctrl_if
  import add_seq_pkg::*;
#(
  parameter int NBYTES = DEFAULT_NBYTES
);

  logic                     start;
  logic [BYTE_W*NBYTES-1:0] a;
  logic [BYTE_W*NBYTES-1:0] b;
  logic                     cin;
`ifdef ADD_SEQ_SUB_EN
  logic                     sub;
`endif
  logic                     busy;
  logic                     done;
  logic [BYTE_W*NBYTES-1:0] sum;
  logic                     cout;
  logic                     ov;

`ifdef ADD_SEQ_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ov);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ov);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ov);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ov);
`endif

endinterface

// File: rtl/add8bit.sv
// Shared 8-bit ripple adder with carry-out and signed overflow.
module add8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout,
  output logic       ov
);

  logic [7:0] low;
  logic [1:0] top;

  // Split at the MSB so the carry into bit 7 is visible for overflow.
  assign low  = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'b0, cin};
  assign top  = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, low[7]};
  assign sum  = {top[0], low[6:0]};
  assign cout = top[1];
  assign ov   = top[1] ^ low[7];

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide adder: one add8bit shared over NBYTES cycles, LSB first.
// Build option: ADD_SEQ_SUB_EN adds subtract (invert B, carry-in forced to 1).
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int NBYTES = DEFAULT_NBYTES
) (
  input logic          clk,
  input logic          rst,
  add_seq_ctrl_if.slave bus
);

  localparam int W = BYTE_W * NBYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              c;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      res_reg;
  logic [W-1:0]      res_next;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] add_sum;
  logic              add_cout;
  logic              add_ov;
`ifdef ADD_SEQ_SUB_EN
  logic              sub_reg;
`endif

  always_comb begin
    a_byte = a_reg[int'(idx)*BYTE_W +: BYTE_W];
`ifdef ADD_SEQ_SUB_EN
    b_byte = b_reg[int'(idx)*BYTE_W +: BYTE_W] ^ {BYTE_W{sub_reg}};
`else
    b_byte = b_reg[int'(idx)*BYTE_W +: BYTE_W];
`endif
    res_next = res_reg;
    res_next[int'(idx)*BYTE_W +: BYTE_W] = add_sum;
  end

  add8bit u_add8bit (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (c),
    .sum  (add_sum),
    .cout (add_cout),
    .ov   (add_ov)
  );

  // The final byte is merged via res_next so sum never shows a partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      c        <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
`ifdef ADD_SEQ_SUB_EN
      sub_reg  <= 1'b0;
`endif
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ov   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            idx      <= '0;
            state    <= RUN;
            bus.busy <= 1'b1;
`ifdef ADD_SEQ_SUB_EN
            sub_reg  <= bus.sub;
            c        <= bus.sub | bus.cin;
`else
            c        <= bus.cin;
`endif
          end
        end
        RUN: begin
          res_reg <= res_next;
          c       <= add_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.sum  <= res_next;
            bus.cout <= add_cout;
            bus.ov   <= add_ov;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
